controle_multiciclo: RTL and testbench

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/ctrl_pkg.sv | 87 ++++++++
 rtl/ctrl_wait_cnt.sv | 27 ++
 rtl/controle_multiciclo.sv | 153 +++++++++++++++
 tb/tb_controle_multiciclo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// fields, ALU operation codes, memory address selects and the decode dispatch.
package ctrl_pkg;

  typedef enum logic [5:0] {
    S_INIT, S_FETCH, S_MEM_WAIT, S_IR_LOAD, S_DECODE,
    S_EXEC_ADD, S_EXEC_SUB, S_EXEC_AND, S_WB_R,
    S_EXEC_ADDI, S_EXEC_ADDIU, S_WB_I,
    S_BEQ, S_BNE, S_JUMP, S_JR,
    S_ADDR_LW, S_ADDR_SW, S_ST, S_LD_WAIT, S_LD_MDR, S_WB_LW,
    S_MD_START, S_MD_WAIT, S_MD_WB,
    S_EXC_OVF, S_EXC_OPC, S_EXC_DIV0,
    S_EXCW_OVF, S_EXCW_OPC, S_EXCW_DIV0,
    S_EXC_MDR, S_EXC_JMP
  } state_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [2:0] ALU_PASSA = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;

  localparam logic [2:0] IORD_PC       = 3'd0;
  localparam logic [2:0] IORD_ALUOUT   = 3'd1;
  localparam logic [2:0] IORD_EXC_OPC  = 3'd2;
  localparam logic [2:0] IORD_EXC_OVF  = 3'd3;
  localparam logic [2:0] IORD_EXC_DIV0 = 3'd4;

  // Exception vector select, shared by the entry and the memory-wait states.
  function automatic logic [2:0] exc_iord(input state_t s);
    logic [2:0] sel;
    sel = IORD_PC;
    case (s)
      S_EXC_OVF,  S_EXCW_OVF:  sel = IORD_EXC_OVF;
      S_EXC_OPC,  S_EXCW_OPC:  sel = IORD_EXC_OPC;
      S_EXC_DIV0, S_EXCW_DIV0: sel = IORD_EXC_DIV0;
      default: ;
    endcase
    return sel;
  endfunction

  // Successor of DECODE; each instruction class gets its own state so that
  // every output stays a pure function of the state register.
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn,
                                      input logic div_zero);
    state_t nxt;
    nxt = S_EXC_OPC;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADD:  nxt = S_EXEC_ADD;
          FN_SUB:  nxt = S_EXEC_SUB;
          FN_AND:  nxt = S_EXEC_AND;
          FN_MULT: nxt = S_MD_START;
          FN_DIV:  nxt = div_zero ? S_EXC_DIV0 : S_MD_START;
          FN_JR:   nxt = S_JR;
          default: nxt = S_EXC_OPC;
        endcase
      end
      OP_ADDI:  nxt = S_EXEC_ADDI;
      OP_ADDIU: nxt = S_EXEC_ADDIU;
      OP_BEQ:   nxt = S_BEQ;
      OP_BNE:   nxt = S_BNE;
      OP_LW:    nxt = S_ADDR_LW;
      OP_SW:    nxt = S_ADDR_SW;
      OP_J:     nxt = S_JUMP;
      default:  nxt = S_EXC_OPC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Loadable down-counter used to time memory and mult/div waits; done is high
// while the count sits at zero.
module ctrl_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-style control unit: Moore FSM with memory-latency waits,
// mult/div handshake with sticky timeout flag, and exception sequencing.
module controle_multiciclo
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int MD_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Overflow,
  input  logic       DivZero,
  input  logic       md_done,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       EQorNE,
  output logic       IRWrite,
  output logic       MemRead_Write,
  output logic       RegWrite,
  output logic       RegALoad,
  output logic       RegBLoad,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic       MDRLoad,
  output logic       HiLoWrite,
  output logic       md_start,
  output logic       ALUSrcA,
  output logic       md_err,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [2:0] IorD,
  output logic [2:0] ALUOp,
  output logic [2:0] PCSrc,
  output logic [3:0] MemtoReg
);

  localparam logic [7:0] MEM_LOAD = 8'(MEM_LAT - 1);
  localparam logic [7:0] MD_LOAD  = 8'(MD_TIMEOUT - 1);

  state_t state;
  logic   mem_load, mem_en, mem_done;
  logic   md_load, md_en, md_tmo;

  // Counters are armed in the state before a wait, so a wait of N cycles
  // leaves on the cycle where the count reaches zero.
  assign mem_load = state inside {S_FETCH, S_ADDR_LW, S_EXC_OVF, S_EXC_OPC, S_EXC_DIV0};
  assign mem_en   = state inside {S_MEM_WAIT, S_LD_WAIT, S_EXCW_OVF, S_EXCW_OPC, S_EXCW_DIV0};
  assign md_load  = (state == S_MD_START);
  assign md_en    = (state == S_MD_WAIT);

  ctrl_wait_cnt #(.W(8)) u_mem_cnt (
    .clk(clk), .reset(reset), .load(mem_load), .en(mem_en),
    .load_val(MEM_LOAD), .done(mem_done)
  );

  ctrl_wait_cnt #(.W(8)) u_md_cnt (
    .clk(clk), .reset(reset), .load(md_load), .en(md_en),
    .load_val(MD_LOAD), .done(md_tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_INIT;
      md_err <= 1'b0;
    end else begin
      case (state)
        S_INIT:       state <= S_FETCH;
        S_FETCH:      state <= S_MEM_WAIT;
        S_MEM_WAIT:   if (mem_done) state <= S_IR_LOAD;
        S_IR_LOAD:    state <= S_DECODE;
        S_DECODE:     state <= dispatch(opcode, funct, DivZero);
        S_EXEC_ADD,
        S_EXEC_SUB:   state <= Overflow ? S_EXC_OVF : S_WB_R;
        S_EXEC_AND:   state <= S_WB_R;
        S_EXEC_ADDI:  state <= Overflow ? S_EXC_OVF : S_WB_I;
        S_EXEC_ADDIU: state <= S_WB_I;
        S_ADDR_LW:    state <= S_LD_WAIT;
        S_ADDR_SW:    state <= S_ST;
        S_LD_WAIT:    if (mem_done) state <= S_LD_MDR;
        S_LD_MDR:     state <= S_WB_LW;
        S_MD_START:   state <= S_MD_WAIT;
        // md_done is checked first so a completion on the last cycle wins.
        S_MD_WAIT: begin
          if (md_done)
            state <= S_MD_WB;
          else if (md_tmo) begin
            md_err <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_EXC_OVF:    state <= S_EXCW_OVF;
        S_EXC_OPC:    state <= S_EXCW_OPC;
        S_EXC_DIV0:   state <= S_EXCW_DIV0;
        S_EXCW_OVF,
        S_EXCW_OPC,
        S_EXCW_DIV0:  if (mem_done) state <= S_EXC_MDR;
        S_EXC_MDR:    state <= S_EXC_JMP;
        S_WB_R, S_WB_I, S_WB_LW, S_BEQ, S_BNE, S_JUMP, S_JR,
        S_ST, S_MD_WB, S_EXC_JMP:
                      state <= S_FETCH;
        default:      state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; EQorNE = 1'b0; IRWrite = 1'b0;
    MemRead_Write = 1'b0; RegWrite = 1'b0; RegALoad = 1'b0; RegBLoad = 1'b0;
    ALUOutWrite = 1'b0; EPCWrite = 1'b0; MDRLoad = 1'b0; HiLoWrite = 1'b0;
    md_start = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'd0; RegDst = 2'd0;
    IorD = IORD_PC; ALUOp = ALU_PASSA; PCSrc = 3'd0; MemtoReg = 4'd0;
    case (state)
      S_INIT:      begin RegWrite = 1'b1; RegDst = 2'd3; MemtoReg = 4'd7; end
      S_FETCH:     begin ALUSrcB = 2'd1; ALUOp = ALU_ADD; PCWrite = 1'b1; end
      S_IR_LOAD:   IRWrite = 1'b1;
      S_DECODE: begin
        RegALoad = 1'b1; RegBLoad = 1'b1; ALUOutWrite = 1'b1;
        ALUSrcB = 2'd3; ALUOp = ALU_ADD;
      end
      S_EXEC_ADD, S_EXEC_SUB, S_EXEC_AND: begin
        ALUSrcA = 1'b1; ALUOutWrite = 1'b1;
        ALUOp = (state == S_EXEC_SUB) ? ALU_SUB :
                (state == S_EXEC_AND) ? ALU_AND : ALU_ADD;
      end
      S_WB_R:      begin RegWrite = 1'b1; RegDst = 2'd1; end
      S_EXEC_ADDI, S_EXEC_ADDIU, S_ADDR_LW, S_ADDR_SW: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'd2; ALUOp = ALU_ADD; ALUOutWrite = 1'b1;
      end
      S_WB_I:      RegWrite = 1'b1;
      S_BEQ, S_BNE: begin
        ALUSrcA = 1'b1; ALUOp = ALU_SUB; PCWriteCond = 1'b1; PCSrc = 3'd1;
        EQorNE = (state == S_BNE);
      end
      S_JUMP:      begin PCSrc = 3'd2; PCWrite = 1'b1; end
      S_JR:        begin ALUSrcA = 1'b1; ALUOp = ALU_PASSA; PCWrite = 1'b1; end
      S_ST:        begin IorD = IORD_ALUOUT; MemRead_Write = 1'b1; end
      S_LD_WAIT:   IorD = IORD_ALUOUT;
      S_LD_MDR, S_EXC_MDR: MDRLoad = 1'b1;
      S_WB_LW:     begin RegWrite = 1'b1; MemtoReg = 4'd1; end
      S_MD_START:  md_start = 1'b1;
      S_MD_WB:     HiLoWrite = 1'b1;
      S_EXC_OVF, S_EXC_OPC, S_EXC_DIV0: begin
        EPCWrite = 1'b1; ALUSrcB = 2'd1; ALUOp = ALU_SUB; IorD = exc_iord(state);
      end
      S_EXCW_OVF, S_EXCW_OPC, S_EXCW_DIV0: IorD = exc_iord(state);
      S_EXC_JMP:   begin PCSrc = 3'd3; PCWrite = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized check of controle_multiciclo against a per-instruction trace model
// built from the instruction-level behaviour of the control unit.
module tb_controle_multiciclo;

  localparam int L  = 3;
  localparam int TO = 12;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_MULT = 3, K_DIV = 4, K_JR = 5;
  localparam int K_ADDI = 6, K_ADDIU = 7, K_BEQ = 8, K_BNE = 9, K_LW = 10;
  localparam int K_SW = 11, K_J = 12, K_ILL = 13;

  typedef struct packed {
    logic PCWrite, PCWriteCond, EQorNE, IRWrite, MemRead_Write, RegWrite;
    logic RegALoad, RegBLoad, ALUOutWrite, EPCWrite, MDRLoad, HiLoWrite;
    logic md_start, ALUSrcA, md_err;
    logic [1:0] ALUSrcB, RegDst;
    logic [2:0] IorD, ALUOp, PCSrc;
    logic [3:0] MemtoReg;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       Overflow = 1'b0, DivZero = 1'b0, md_done = 1'b0;
  logic       PCWrite, PCWriteCond, EQorNE, IRWrite, MemRead_Write, RegWrite;
  logic       RegALoad, RegBLoad, ALUOutWrite, EPCWrite, MDRLoad, HiLoWrite;
  logic       md_start, ALUSrcA, md_err;
  logic [1:0] ALUSrcB, RegDst;
  logic [2:0] IorD, ALUOp, PCSrc;
  logic [3:0] MemtoReg;

  out_t obs;
  assign obs = {PCWrite, PCWriteCond, EQorNE, IRWrite, MemRead_Write, RegWrite,
                RegALoad, RegBLoad, ALUOutWrite, EPCWrite, MDRLoad, HiLoWrite,
                md_start, ALUSrcA, md_err, ALUSrcB, RegDst, IorD, ALUOp, PCSrc, MemtoReg};

  controle_multiciclo #(.MEM_LAT(L), .MD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .Overflow(Overflow), .DivZero(DivZero), .md_done(md_done),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .EQorNE(EQorNE), .IRWrite(IRWrite),
    .MemRead_Write(MemRead_Write), .RegWrite(RegWrite), .RegALoad(RegALoad),
    .RegBLoad(RegBLoad), .ALUOutWrite(ALUOutWrite), .EPCWrite(EPCWrite),
    .MDRLoad(MDRLoad), .HiLoWrite(HiLoWrite), .md_start(md_start), .ALUSrcA(ALUSrcA),
    .md_err(md_err), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .IorD(IorD), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .MemtoReg(MemtoReg)
  );

  always #5 clk = ~clk;

  int   nchecks = 0;
  int   nerr = 0;
  bit   err_m = 1'b0;
  out_t expq[$];
  bit   mdq[$];

  logic [5:0] kop[13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                          6'h08, 6'h09, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h02};
  logic [5:0] kfn[6]  = '{6'h20, 6'h22, 6'h24, 6'h18, 6'h1a, 6'h08};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    int k;
    k = K_ILL;
    if (op == 6'h00) begin
      for (int i = 0; i < 6; i++) if (fn == kfn[i]) k = i;
    end else begin
      for (int i = 6; i < 13; i++) if (op == kop[i]) k = i;
    end
    return k;
  endfunction

  task automatic add(input out_t e, input bit md);
    out_t t;
    t = e;
    t.md_err = err_m;
    expq.push_back(t);
    mdq.push_back(md);
  endtask

  function automatic out_t init_word();
    out_t e;
    e = '0; e.RegWrite = 1'b1; e.RegDst = 2'd3; e.MemtoReg = 4'd7;
    return e;
  endfunction

  // Builds the expected per-cycle trace from FETCH up to the next FETCH,
  // then plays it; abort>=0 asserts reset after that trace cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input bit ovf, input bit dz, input int d, input int abort);
    out_t e, z;
    int   k, exc;
    bit   tmo;
    z = '0; k = classify(op, fn); exc = 0; tmo = 1'b0;
    expq.delete(); mdq.delete();
    e = '0; e.PCWrite = 1; e.ALUSrcB = 2'd1; e.ALUOp = 3'd1; add(e, rb());
    repeat (L) add(z, rb());
    e = '0; e.IRWrite = 1; add(e, rb());
    e = '0; e.RegALoad = 1; e.RegBLoad = 1; e.ALUOutWrite = 1; e.ALUSrcB = 2'd3;
    e.ALUOp = 3'd1; add(e, rb());
    case (k)
      K_ADD, K_SUB, K_AND: begin
        e = '0; e.ALUSrcA = 1; e.ALUOutWrite = 1;
        e.ALUOp = (k == K_ADD) ? 3'd1 : (k == K_SUB) ? 3'd2 : 3'd3;
        add(e, rb());
        if (ovf && k != K_AND) exc = 3;
        else begin e = '0; e.RegWrite = 1; e.RegDst = 2'd1; add(e, rb()); end
      end
      K_ADDI, K_ADDIU: begin
        e = '0; e.ALUSrcA = 1; e.ALUSrcB = 2'd2; e.ALUOp = 3'd1; e.ALUOutWrite = 1;
        add(e, rb());
        if (ovf && k == K_ADDI) exc = 3;
        else begin e = '0; e.RegWrite = 1; add(e, rb()); end
      end
      K_BEQ, K_BNE: begin
        e = '0; e.ALUSrcA = 1; e.ALUOp = 3'd2; e.PCWriteCond = 1; e.PCSrc = 3'd1;
        e.EQorNE = (k == K_BNE); add(e, rb());
      end
      K_J:  begin e = '0; e.PCSrc = 3'd2; e.PCWrite = 1; add(e, rb()); end
      K_JR: begin e = '0; e.ALUSrcA = 1; e.PCWrite = 1; add(e, rb()); end
      K_LW, K_SW: begin
        e = '0; e.ALUSrcA = 1; e.ALUSrcB = 2'd2; e.ALUOp = 3'd1; e.ALUOutWrite = 1;
        add(e, rb());
        if (k == K_SW) begin
          e = '0; e.IorD = 3'd1; e.MemRead_Write = 1; add(e, rb());
        end else begin
          e = '0; e.IorD = 3'd1; repeat (L) add(e, rb());
          e = '0; e.MDRLoad = 1; add(e, rb());
          e = '0; e.RegWrite = 1; e.MemtoReg = 4'd1; add(e, rb());
        end
      end
      K_MULT, K_DIV: begin
        if (k == K_DIV && dz) exc = 4;
        else begin
          e = '0; e.md_start = 1; add(e, rb());
          for (int j = 1; j <= TO; j++) begin
            add(z, (j == d));
            if (j == d) break;
          end
          if (d >= 1 && d <= TO) begin e = '0; e.HiLoWrite = 1; add(e, rb()); end
          else tmo = 1'b1;
        end
      end
      default: exc = 2;
    endcase
    if (exc != 0) begin
      e = '0; e.EPCWrite = 1; e.ALUSrcB = 2'd1; e.ALUOp = 3'd2; e.IorD = 3'(exc);
      add(e, rb());
      e = '0; e.IorD = 3'(exc); repeat (L) add(e, rb());
      e = '0; e.MDRLoad = 1; add(e, rb());
      e = '0; e.PCSrc = 3'd3; e.PCWrite = 1; add(e, rb());
    end
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin opcode = op; funct = fn; Overflow = ovf; DivZero = dz; end
      check($sformatf("%s[%0d]", name, i), obs, expq[i]);
      md_done = mdq[i];
      if (i == abort) begin
        reset = 1'b1; md_done = 1'b0;
        @(negedge clk);
        err_m = 1'b0;
        check($sformatf("%s_reset_init", name), obs, init_word());
        reset = 1'b0;
        return;
      end
    end
    if (tmo) err_m = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int k;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_init", obs, init_word());
    reset = 1'b0;

    run_instr("add",        6'h00, 6'h20, 0, 0, 0, -1);
    run_instr("addi_ovf",   6'h08, 6'h11, 1, 0, 0, -1);
    run_instr("addiu_ovf",  6'h09, 6'h11, 1, 0, 0, -1);
    run_instr("sub_ovf",    6'h00, 6'h22, 1, 0, 0, -1);
    run_instr("and_ovf",    6'h00, 6'h24, 1, 0, 0, -1);
    run_instr("bad_opc",    6'h3f, 6'h00, 0, 0, 0, -1);
    run_instr("bad_funct",  6'h00, 6'h3f, 0, 0, 0, -1);
    run_instr("div_zero",   6'h00, 6'h1a, 0, 1, 5, -1);
    run_instr("mult_d10",   6'h00, 6'h18, 0, 0, 10, -1);
    run_instr("div_edge",   6'h00, 6'h1a, 0, 0, TO, -1);
    run_instr("bne",        6'h05, 6'h00, 0, 0, 0, -1);
    run_instr("beq",        6'h04, 6'h00, 0, 0, 0, -1);
    run_instr("sw",         6'h2b, 6'h00, 0, 0, 0, -1);
    run_instr("lw",         6'h23, 6'h00, 0, 0, 0, -1);
    run_instr("j",          6'h02, 6'h00, 0, 0, 0, -1);
    run_instr("jr",         6'h00, 6'h08, 0, 0, 0, -1);
    run_instr("lw_abort",   6'h23, 6'h00, 0, 0, 0, L + 5);
    run_instr("mult_tmo",   6'h00, 6'h18, 0, 0, 0, -1);
    run_instr("after_tmo",  6'h00, 6'h20, 0, 0, 0, -1);
    run_instr("mult_abort", 6'h00, 6'h18, 0, 0, 0, L + 6);
    run_instr("after_rst",  6'h00, 6'h24, 0, 0, 0, -1);

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 13);
      if (k == K_ILL) begin
        do begin
          op = 6'($urandom); fn = 6'($urandom);
        end while (classify(op, fn) != K_ILL);
      end else begin
        op = kop[k];
        fn = (k < 6) ? kfn[k] : 6'($urandom);
      end
      run_instr($sformatf("rnd%0d", n), op, fn, rb(), rb(), $urandom_range(0, TO + 2), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
